// File: rtl/vexec_pkg.sv
// vexec_pkg -- shared types and helpers for the vector execute stage.
//   vexec_op_e      : 4-bit opcode encoding (10..15 are unsupported)
//   vexec_state_e   : execute-stage sequencing states (IDLE, MUL)
//   DEFAULT_REG_SIZE: default lane width
//   shamt_width()   : number of low operand bits used as a shift amount
package vexec_pkg;

    localparam int DEFAULT_REG_SIZE = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MUL  = 4'd8,
        OP_MOVA = 4'd9
    } vexec_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } vexec_state_e;

    function automatic int shamt_width(input int reg_size);
        return (reg_size > 1) ? $clog2(reg_size) : 1;
    endfunction

endpackage

// File: rtl/vexec_lane_alu.sv
// vexec_lane_alu -- combinational single-lane ALU.
//   op : opcode (vexec_op_e encoding)
//   a,b: lane operands
//   y  : lane result; zero for MUL and for unsupported opcodes (MUL is
//        handled by the shared multiplier in the top level)
module vexec_lane_alu
    import vexec_pkg::*;
#(
    parameter int REG_SIZE = DEFAULT_REG_SIZE
) (
    input  logic [3:0]          op,
    input  logic [REG_SIZE-1:0] a,
    input  logic [REG_SIZE-1:0] b,
    output logic [REG_SIZE-1:0] y
);

    localparam int SHW = shamt_width(REG_SIZE);

    // Only the low bits of b select the shift distance; upper bits ignored.
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            OP_MOVA: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vect_exec_stage.sv
// vect_exec_stage -- vector execute stage of the SIMD pipeline.
//   clk, reset        : clock, asynchronous active-high reset
//   in_valid/in_ready : operation handshake (in_ready low while a MUL runs)
//   op, ctrl_in       : opcode and pass-through control word
//   vect_a, vect_b    : operand vectors (VECT_SIZE lanes of REG_SIZE bits)
//   flush             : synchronous abort; wins over in_valid
//   out_valid         : one-cycle completion pulse
//   result, ctrl_out  : registered result vector and its control word
//   illegal_op        : qualifies out_valid; opcode was unsupported
// Build option: define VEXEC_MUL_EN to include the lane-serial multiplier.
// Without it opcode 8 completes as an illegal op and in_ready is constant 1.
module vect_exec_stage
    import vexec_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int REG_SIZE  = DEFAULT_REG_SIZE,
    parameter int VECT_SIZE = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [3:0]                         op,
    input  logic [WIDTH-1:0]                   ctrl_in,
    input  logic [VECT_SIZE-1:0][REG_SIZE-1:0] vect_a,
    input  logic [VECT_SIZE-1:0][REG_SIZE-1:0] vect_b,
    input  logic                               flush,
    output logic                               out_valid,
    output logic [VECT_SIZE-1:0][REG_SIZE-1:0] result,
    output logic [WIDTH-1:0]                   ctrl_out,
    output logic                               illegal_op
);

`ifdef VEXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic [VECT_SIZE-1:0][REG_SIZE-1:0] alu_y;
    logic                               op_illegal;
    logic                               busy;
    logic                               accept;

    genvar gi;
    generate
        for (gi = 0; gi < VECT_SIZE; gi++) begin : g_lane
            vexec_lane_alu #(
                .REG_SIZE(REG_SIZE)
            ) u_alu (
                .op(op),
                .a (vect_a[gi]),
                .b (vect_b[gi]),
                .y (alu_y[gi])
            );
        end
    endgenerate

    assign op_illegal = (op > 4'd9) || ((op == OP_MUL) && !MUL_EN);
    assign in_ready   = !busy;
    assign accept     = in_valid && in_ready && !flush;

`ifdef VEXEC_MUL_EN
    localparam int IDX_W = (VECT_SIZE > 1) ? $clog2(VECT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECT_SIZE - 1);

    vexec_state_e                       state_reg;
    logic [IDX_W-1:0]                   idx_reg;
    logic [VECT_SIZE-1:0][REG_SIZE-1:0] a_reg;
    logic [VECT_SIZE-1:0][REG_SIZE-1:0] b_reg;
    logic [VECT_SIZE-1:0][REG_SIZE-1:0] mul_acc_reg;
    logic [VECT_SIZE-1:0][REG_SIZE-1:0] mul_final;
    logic [WIDTH-1:0]                   ctrl_reg;
    logic [REG_SIZE-1:0]                mul_prod;

    // One shared multiplier; only the low REG_SIZE bits are kept.
    assign mul_prod = a_reg[idx_reg] * b_reg[idx_reg];

    // Accumulated lanes with the lane being finished this cycle merged in,
    // so the last lane can be published on the same edge it is computed.
    always_comb begin
        mul_final          = mul_acc_reg;
        mul_final[idx_reg] = mul_prod;
    end

    assign busy = (state_reg == MUL);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            illegal_op  <= 1'b0;
            result      <= '0;
            ctrl_out    <= '0;
`ifdef VEXEC_MUL_EN
            state_reg   <= IDLE;
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mul_acc_reg <= '0;
            ctrl_reg    <= '0;
`endif
        end else begin
            // Completion flags are pulses; result/ctrl_out hold otherwise.
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
            if (flush) begin
`ifdef VEXEC_MUL_EN
                // Drop any partially built MUL result.
                state_reg <= IDLE;
                idx_reg   <= '0;
`endif
            end else begin
`ifdef VEXEC_MUL_EN
                if (state_reg == MUL) begin
                    mul_acc_reg[idx_reg] <= mul_prod;
                    if (idx_reg == LAST_IDX) begin
                        result    <= mul_final;
                        ctrl_out  <= ctrl_reg;
                        out_valid <= 1'b1;
                        state_reg <= IDLE;
                        idx_reg   <= '0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end else if (accept && (op == OP_MUL)) begin
                    a_reg     <= vect_a;
                    b_reg     <= vect_b;
                    ctrl_reg  <= ctrl_in;
                    idx_reg   <= '0;
                    state_reg <= MUL;
                end else
`endif
                if (accept) begin
                    result     <= alu_y;
                    ctrl_out   <= ctrl_in;
                    out_valid  <= 1'b1;
                    illegal_op <= op_illegal;
                end
            end
        end
    end

endmodule

// File: doc/vect_exec_stage.md
# vect_exec_stage

Vector execute stage of the SIMD pipeline: consumes the operand vectors and control word delivered by the ID/EX vector pipeline register and produces a registered result vector for the EX/MEM vector pipeline register. Single-cycle lane-parallel ALU ops complete in one cycle. MUL executes lane-serially over VECT_SIZE cycles through one shared multiplier, with a ready/valid handshake that stalls upstream.

## Interface
- WIDTH, 8: width of the pass-through control word
- REG_SIZE, 32: lane width in bits
- VECT_SIZE, 4: number of lanes
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  stage can accept; equals !busy
- op  in  4  opcode
- ctrl_in  in  WIDTH  control word carried with the operation
- vect_a, vect_b  in  [VECT_SIZE-1:0][REG_SIZE-1:0]  operand vectors
- flush  in  1  synchronous abort
- out_valid  out  1  result valid this cycle (one-cycle pulse per op)
- result  out  [VECT_SIZE-1:0][REG_SIZE-1:0]  result vector
- ctrl_out  out  WIDTH  ctrl_in of the completed op
- illegal_op  out  1  qualifies out_valid; opcode was unsupported

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9 MOVA (result = vect_a); 10–15 illegal.
- Arithmetic is modulo 2^REG_SIZE per lane; no carry between lanes. MUL keeps the low REG_SIZE bits of the unsigned product.
- Shift amount per lane is b[$clog2(REG_SIZE)-1:0]; the upper bits are ignored.
- Illegal opcode: result all zero, illegal_op=1, out_valid=1, latency 1.
- Accept occurs when in_valid && in_ready && !flush. Operands, op and ctrl_in are captured on accept.
- States:
  - IDLE: on accept of a non-MUL op, stays in IDLE. On accept of MUL, goes to MUL with lane index 0.
  - MUL: on each edge, lane[idx] = a[idx]*b[idx] and idx increments. After lane VECT_SIZE-1 the result is published and the state returns to IDLE.
- in_valid while busy is ignored; upstream must hold the op until in_ready is high.
- flush:
  - Returns the state to IDLE and discards any partial MUL.
  - out_valid is 0 on the next edge.
  - Takes priority over a simultaneous in_valid, which is not accepted.
- Reset:
  - State IDLE, idx 0.
  - out_valid, illegal_op, in_ready-internal busy cleared to 0.
  - result and ctrl_out cleared to 0.

## Timing
- Non-MUL op accepted at edge N: result, ctrl_out and out_valid=1 appear after edge N, so latency is 1. Back-to-back accepts give one result per cycle.
- MUL accepted at edge N:
  - in_ready=0 from after edge N until after edge N+VECT_SIZE.
  - out_valid=1 after edge N+VECT_SIZE, so latency is VECT_SIZE.
  - A new op can be accepted at edge N+VECT_SIZE+1.
- out_valid is 0 on every cycle without a completion. result and ctrl_out hold their last value.
- Reset asserted mid-MUL: outputs return to their reset values immediately, and no completion is produced.

## Configuration
- VEXEC_MUL_EN:
  - Defined: MUL behaves as above.
  - Undefined: opcode 8 is treated as illegal (zero result, illegal_op=1, latency 1). The MUL state, the multiplier and the lane index are not synthesized, and in_ready is constant 1.

## Structure
- Package vexec_pkg holds:
  - the opcode enum (vexec_op_e)
  - the state enum (IDLE, MUL)
  - a default lane-width constant and the shift-amount width function.
- Sub-module vexec_lane_alu is a combinational single-lane ALU for ops 0–7, 9 and illegal, instantiated VECT_SIZE times. The top holds the FSM, the shared multiplier and the output registers.

## Test plan
- ADD lanes a={1,2,3,0xFFFFFFFF}, b={1,1,1,1} → out_valid after 1 edge, result={2,3,4,0}, ctrl_out=ctrl_in.
- SRA a lane=0x80000000, b=0x24 (shift 4) → 0xF8000000. SLL with b=0x21 → shift 1.
- MUL a={2,3,4,0x10000}, b={5,6,7,0x10000} → in_ready low 4 cycles, single out_valid at edge N+4, result={10,18,28,0}. An in_valid held during busy is accepted only after completion.
- flush asserted at MUL cycle 2, together with in_valid of an ADD → no out_valid, state IDLE, ADD not accepted; the next cycle's ADD completes normally.
- Opcode 12 → result 0, illegal_op=1 for one cycle. Without VEXEC_MUL_EN, opcode 8 behaves the same and in_ready stays 1.
- reset pulsed mid-MUL → all outputs 0 immediately, in_ready=1 after release, and no stale completion follows.
